// File: rtl/spi_slave_if_if.sv
// Controller-side bus of the SPI slave front end: received byte stream,
// synchronized chip select and the reply-byte handshake.
interface spi_slave_if_if;
  logic [7:0]  data_out;
  logic        data_out_ready;
  logic        cs_n_sync;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_underrun;
  logic [15:0] byte_count;

  modport slave (
    output data_out, data_out_ready, cs_n_sync, tx_ready, tx_underrun, byte_count,
    input  tx_data, tx_valid
  );

  modport master (
    input  data_out, data_out_ready, cs_n_sync, tx_ready, tx_underrun, byte_count,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversamples the SPI pins in clk_sys, assembles
// MSB-first bytes and shifts reply bytes out on MISO.
module spi_slave_if #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         cs_n,
  output logic         miso,
  output logic         miso_oe,
  spi_slave_if_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_d_q, sclk_d_d;
  logic                   cs_d_q, cs_d_d;

  logic [BYTE_W-2:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-2:0] tx_shift_q, tx_shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              data_out_ready_q, data_out_ready_d;
  logic              cs_n_sync_q, cs_n_sync_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_underrun_q, tx_underrun_d;

  logic              sclk_s, mosi_s, cs_s;
  logic              rise, fall, cs_fall;
  logic              tx_load, tx_shift_en;
  logic [BYTE_W-1:0] tx_load_val;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign rise        = sclk_s & ~sclk_d_q;
  assign fall        = ~sclk_s & sclk_d_q;
  assign cs_fall     = cs_d_q & ~cs_s;
  assign tx_load_val = bus.tx_valid ? bus.tx_data : BYTE_W'(0);

  // State register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; a high chip select always ends the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_s)    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; frame exit beats any SCLK edge in the same cycle
  always_comb begin
    sclk_sync_d      = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d      = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d        = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_d_d         = sclk_s;
    cs_d_d           = cs_s;
    rx_shift_d       = rx_shift_q;
    tx_shift_d       = tx_shift_q;
    bit_cnt_d        = bit_cnt_q;
    byte_count_d     = byte_count_q;
    data_out_d       = data_out_q;
    data_out_ready_d = 1'b0;
    cs_n_sync_d      = cs_s;
    miso_d           = miso_q;
    miso_oe_d        = miso_oe_q;
    tx_ready_d       = 1'b0;
    tx_underrun_d    = tx_underrun_q;
    tx_load          = 1'b0;
    tx_shift_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          bit_cnt_d    = '0;
          byte_count_d = '0;
          miso_oe_d    = 1'b1;
          tx_load      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_s) begin
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end else if (rise) begin
          rx_shift_d = {rx_shift_q[BYTE_W-3:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(7)) begin
            data_out_d       = {rx_shift_q, mosi_s};
            data_out_ready_d = 1'b1;
            if (byte_count_q != {CNT_W{1'b1}}) byte_count_d = byte_count_q + CNT_W'(1);
          end
        end else if (fall) begin
          if (bit_cnt_q == '0 && byte_count_q != '0) tx_load = 1'b1;
          else                                       tx_shift_en = 1'b1;
        end
      end
      default: ;
    endcase

    // MISO presents bit 7 of the loaded byte; tx_shift keeps the remaining bits
    if (tx_load) begin
      tx_shift_d = tx_load_val[BYTE_W-2:0];
      miso_d     = tx_load_val[BYTE_W-1];
      tx_ready_d = bus.tx_valid;
      if (!bus.tx_valid) tx_underrun_d = 1'b1;
    end else if (tx_shift_en) begin
      miso_d     = tx_shift_q[BYTE_W-2];
      tx_shift_d = {tx_shift_q[BYTE_W-3:0], 1'b0};
    end
  end

  // Datapath registers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sclk_sync_q      <= '0;
      mosi_sync_q      <= '0;
      cs_sync_q        <= '0;
      sclk_d_q         <= 1'b0;
      cs_d_q           <= 1'b0;
      rx_shift_q       <= '0;
      tx_shift_q       <= '0;
      bit_cnt_q        <= '0;
      byte_count_q     <= '0;
      data_out_q       <= '0;
      data_out_ready_q <= 1'b0;
      cs_n_sync_q      <= 1'b1;
      miso_q           <= 1'b0;
      miso_oe_q        <= 1'b0;
      tx_ready_q       <= 1'b0;
      tx_underrun_q    <= 1'b0;
    end else begin
      sclk_sync_q      <= sclk_sync_d;
      mosi_sync_q      <= mosi_sync_d;
      cs_sync_q        <= cs_sync_d;
      sclk_d_q         <= sclk_d_d;
      cs_d_q           <= cs_d_d;
      rx_shift_q       <= rx_shift_d;
      tx_shift_q       <= tx_shift_d;
      bit_cnt_q        <= bit_cnt_d;
      byte_count_q     <= byte_count_d;
      data_out_q       <= data_out_d;
      data_out_ready_q <= data_out_ready_d;
      cs_n_sync_q      <= cs_n_sync_d;
      miso_q           <= miso_d;
      miso_oe_q        <= miso_oe_d;
      tx_ready_q       <= tx_ready_d;
      tx_underrun_q    <= tx_underrun_d;
    end
  end

  assign miso               = miso_q;
  assign miso_oe            = miso_oe_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_ready = data_out_ready_q;
  assign bus.cs_n_sync      = cs_n_sync_q;
  assign bus.tx_ready       = tx_ready_q;
  assign bus.tx_underrun    = tx_underrun_q;
  assign bus.byte_count     = byte_count_q;

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI slave front end that converts the host's serial link into the byte stream and chip-select consumed by the device command controller. It samples the asynchronous SCLK, MOSI and CS_N pins in the clk_sys domain and assembles MSB-first bytes, emitting one single-cycle `data_out_ready` strobe per byte. It also shifts an optional reply byte stream out on MISO.

## Interface

Parameters:
- SYNC_STAGES, 2: synchronizer depth for sclk, mosi and cs_n pins (≥2).

Ports (reset reset_n, synchronous, active-low; clock clk_sys):
- clk_sys  in  1  system clock; must be ≥8× SCLK frequency.
- reset_n  in  1  synchronous active-low reset.
- sclk  in  1  SPI clock pin, async, CPOL=0.
- mosi  in  1  SPI data in, async.
- cs_n  in  1  SPI chip select pin, async, active-low.
- miso  out  1  SPI data out.
- miso_oe  out  1  MISO output enable; high while the frame is active.
- data_out  out  8  last received byte; feeds the controller's data_in.
- data_out_ready  out  1  one-cycle strobe, data_out valid.
- cs_n_sync  out  1  synchronized chip select; feeds the controller's cs_n.
- tx_data  in  8  next reply byte.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  one-cycle strobe, tx_data consumed.
- tx_underrun  out  1  sticky; a reply byte was needed while tx_valid was low.
- byte_count  out  16  bytes received in the current frame, saturating at 16'hFFFF.

## Operation

- Synchronize sclk, mosi and cs_n through SYNC_STAGES flops each, giving sclk_s, mosi_s and cs_s. sclk_d is sclk_s delayed one cycle.
  - rise = sclk_s & ~sclk_d
  - fall = ~sclk_s & sclk_d
- States:
  - IDLE: cs_s high.
  - ACTIVE: cs_s low.
- IDLE → ACTIVE on cs_s falling.
  - Clear bit_cnt and byte_count.
  - Perform a tx load.
  - Set miso_oe=1.
- ACTIVE → IDLE when cs_s is high.
  - This takes priority over any edge in the same cycle.
  - Discard a partial byte; no strobe.
  - Set miso_oe=0 and miso=0.
- RX, on each rise in ACTIVE:
  - rx_shift <= {rx_shift[6:0], mosi_s}.
  - bit_cnt increments and wraps 7→0.
  - When bit_cnt==7:
    - data_out <= {rx_shift[6:0], mosi_s}
    - data_out_ready <= 1 for exactly one cycle
    - byte_count increments, saturating.
- TX, mode 0, MSB first:
  - A tx load loads tx_shift <= tx_valid ? tx_data : 8'h00 and drives miso <= bit 7 of the loaded value.
  - If tx_valid=1, pulse tx_ready for one cycle.
  - If tx_valid=0, set tx_underrun.
  - On each fall in ACTIVE:
    - If bit_cnt==0 and byte_count>0, this is a byte boundary: perform a tx load.
    - Otherwise, shift tx_shift left one bit; miso <= new bit 7.
- tx_underrun clears only on reset_n.
- data_out holds its value between strobes and is not cleared at frame end.
- cs_n_sync = cs_s, registered.

## Timing

- Reset values:
  - miso=0, miso_oe=0
  - data_out=8'h00, data_out_ready=0
  - cs_n_sync=1
  - tx_ready=0, tx_underrun=0
  - byte_count=0
  - state=IDLE
  - internal shift registers and bit_cnt = 0
- Pin-to-detect latency is SYNC_STAGES+1 cycles from a pin edge to the rise/fall cycle.
- data_out_ready asserts on the clock edge ending the rise-detect cycle of bit 8, i.e. SYNC_STAGES+2 cycles after the 8th SCLK pin rising edge.
- cs_n_sync and data_out_ready are aligned to the same synchronizer depth.
  - Downstream therefore sees the final strobe before cs_n_sync rises, provided SCLK-last-rise to CS_N-rise ≥ 2 clk_sys cycles.
- The first-byte tx load completes SYNC_STAGES+1 cycles after the CS_N pin falls. The host must wait ≥ SYNC_STAGES+2 cycles before the first SCLK rise.
- tx_ready pulses in the cycle following the load.
- Reset mid-frame forces all reset values immediately.
  - After reset, the state is IDLE even if the cs_n pin is low.
  - A new frame requires a fresh cs_s falling edge.
- Glitch-free operation requires SCLK high and low phases ≥ 3 clk_sys cycles.

## Test plan

- Single byte: CS low, shift 0xA5, CS high → one data_out_ready pulse, data_out=0xA5, byte_count=1, cs_n_sync returns 1.
- Write command stream: frame 0x0A,0x00,0x00,0x01,0x00,0x11,0x22 → 7 strobes in order with those values, byte_count=7, no strobe after cs_n_sync rises.
- Abort: CS low, 5 bits of 0xFF, CS high, then a new frame of 0x3C → no strobe for the partial byte; exactly one strobe with 0x3C; byte_count=1.
- Reply path: tx_data=0x81 with tx_valid=1 before CS falls; second byte 0x5A presented after the first tx_ready → MISO sampled on host rises reads 0x81 then 0x5A; two tx_ready pulses; tx_underrun=0.
- Underrun: tx_valid=0 for a whole 2-byte frame → MISO reads 0x00,0x00; tx_underrun=1 and stays set after CS high until reset_n.
- Reset mid-frame: assert reset_n=0 after 3 bits with CS held low; release → all outputs at reset values; no strobe until CS is cycled high→low and a full byte is sent.
